// File: rtl/axi_ad9467_delay_cal.sv
// IDELAY tap sweep for the AD9467 interface: scan all 32 taps against the PN monitor,
// pick the centre of the widest clean window, load it on every lane and read it back.
module axi_ad9467_delay_cal #(
    parameter int unsigned DATA_WIDTH    = 9,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned CHECK_CYCLES  = 256,
    parameter int unsigned MIN_WINDOW    = 3
) (
    input  logic                      up_clk,
    input  logic                      up_rst,
    input  logic                      cal_start,
    input  logic                      cal_abort,
    input  logic                      up_status_pn_err,
    input  logic                      up_status_pn_oos,
    input  logic [5*DATA_WIDTH-1:0]   up_drdata,
    output logic [DATA_WIDTH-1:0]     up_dld,
    output logic [5*DATA_WIDTH-1:0]   up_dwdata,
    output logic                      cal_busy,
    output logic                      cal_done,
    output logic                      cal_fail,
    output logic [4:0]                cal_tap,
    output logic [5:0]                cal_width
);

    localparam int unsigned CntMax = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] CheckLast  = CntW'(CHECK_CYCLES - 1);
    localparam logic [5:0]      MinWin     = 6'(MIN_WINDOW);

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StSettle,
        StCheck,
        StEval,
        StApply,
        StASettle,
        StVerify,
        StEnd
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      tap_q, tap_d;
    logic            pass_q, pass_d;
    logic [5:0]      run_len_q, run_len_d;
    logic [4:0]      run_start_q, run_start_d;
    logic [5:0]      best_len_q, best_len_d;
    logic [4:0]      best_start_q, best_start_d;
    logic            ok_q, ok_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;
    logic [4:0]      res_tap_q, res_tap_d;
    logic [5:0]      res_width_q, res_width_d;

    logic [4:0] center;
    logic [5:0] ext_len;
    logic [4:0] ext_start;
    logic [5:0] fin_len;
    logic       lanes_match;
    logic       load_en;
    logic [4:0] load_val;

    // best_len is never 0 when the centre is consumed, so the subtraction cannot wrap
    assign center = best_start_q + 5'((best_len_q - 6'd1) >> 1);

    always_comb begin
        ext_len   = pass_q ? run_len_q + 6'd1 : run_len_q;
        ext_start = (pass_q && run_len_q == 6'd0) ? tap_q : run_start_q;
        fin_len   = (ext_len > best_len_q) ? ext_len : best_len_q;
    end

    always_comb begin
        lanes_match = 1'b1;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (up_drdata[5*i +: 5] != center) begin
                lanes_match = 1'b0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tap_d        = tap_q;
        pass_d       = pass_q;
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        ok_d         = ok_q;
        done_d       = done_q;
        fail_d       = fail_q;
        res_tap_d    = res_tap_q;
        res_width_d  = res_width_q;

        unique case (state_q)
            StIdle: begin
                if (cal_start) begin
                    state_d      = StLoad;
                    cnt_d        = '0;
                    tap_d        = 5'd0;
                    pass_d       = 1'b0;
                    run_len_d    = 6'd0;
                    run_start_d  = 5'd0;
                    best_len_d   = 6'd0;
                    best_start_d = 5'd0;
                    ok_d         = 1'b0;
                    done_d       = 1'b0;
                    fail_d       = 1'b0;
                end
            end
            StLoad: begin
                state_d = StSettle;
                cnt_d   = '0;
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCheck;
                    cnt_d   = '0;
                    pass_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                pass_d = pass_q & ~up_status_pn_err & ~up_status_pn_oos;
                if (cnt_q == CheckLast) begin
                    state_d = StEval;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEval: begin
                // A failing tap or the last tap closes the run; ties keep the earlier window
                if (!pass_q || tap_q == 5'd31) begin
                    if (ext_len > best_len_q) begin
                        best_len_d   = ext_len;
                        best_start_d = ext_start;
                    end
                    run_len_d = 6'd0;
                end else begin
                    run_len_d   = ext_len;
                    run_start_d = ext_start;
                end
                if (tap_q == 5'd31) begin
                    if (fin_len < MinWin) begin
                        state_d = StEnd;
                        ok_d    = 1'b0;
                    end else begin
                        state_d = StApply;
                    end
                end else begin
                    tap_d   = tap_q + 5'd1;
                    state_d = StLoad;
                end
            end
            StApply: begin
                state_d = StASettle;
                cnt_d   = '0;
            end
            StASettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StVerify;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StVerify: begin
                ok_d    = lanes_match;
                state_d = StEnd;
            end
            StEnd: begin
                done_d      = ok_q;
                fail_d      = ~ok_q;
                res_tap_d   = ok_q ? center : 5'd0;
                res_width_d = best_len_q;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (cal_abort && state_q != StIdle) begin
            state_d = StIdle;
            cnt_d   = '0;
            done_d  = 1'b0;
            fail_d  = 1'b1;
        end
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tap_q        <= 5'd0;
            pass_q       <= 1'b0;
            run_len_q    <= 6'd0;
            run_start_q  <= 5'd0;
            best_len_q   <= 6'd0;
            best_start_q <= 5'd0;
            ok_q         <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            res_tap_q    <= 5'd0;
            res_width_q  <= 6'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tap_q        <= tap_d;
            pass_q       <= pass_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            ok_q         <= ok_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            res_tap_q    <= res_tap_d;
            res_width_q  <= res_width_d;
        end
    end

    // Load strobe is masked by abort and reset so no tap is written in those cycles
    assign load_en   = (state_q == StLoad || state_q == StApply) && !cal_abort && !up_rst;
    assign load_val  = (state_q == StApply) ? center : tap_q;
    assign up_dld    = {DATA_WIDTH{load_en}};
    assign up_dwdata = load_en ? {DATA_WIDTH{load_val}} : '0;

    assign cal_busy  = (state_q != StIdle);
    assign cal_done  = done_q;
    assign cal_fail  = fail_q;
    assign cal_tap   = res_tap_q;
    assign cal_width = res_width_q;

endmodule

// File: tb/tb_axi_ad9467_delay_cal.sv
// Bench for axi_ad9467_delay_cal: models the delay lines and PN monitor around the DUT
// and predicts the calibration outcome from the per-tap pass map.
module tb_axi_ad9467_delay_cal;

    localparam int DW = 9;
    localparam int S  = 4;
    localparam int C  = 8;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          up_rst = 1'b1;
    logic          cal_start = 1'b0;
    logic          cal_abort = 1'b0;
    logic          pn_err = 1'b0;
    logic          pn_oos = 1'b0;
    logic [5*DW-1:0] up_drdata;
    logic [DW-1:0] up_dld;
    logic [5*DW-1:0] up_dwdata;
    logic          cal_busy, cal_done, cal_fail;
    logic [4:0]    cal_tap;
    logic [5:0]    cal_width;

    int n_vec = 0;
    int n_err = 0;

    // Environment state: delay-line contents, PN behaviour per tap
    logic [4:0]  drd [DW];
    logic [31:0] pass_mask = 32'd0;
    int          glitch_tap = -1;
    bit          stuck = 1'b0;
    logic [4:0]  cur_tap = 5'd0;
    int          since_load = 1000;
    int          dld_total = 0;

    always #5 clk = ~clk;

    axi_ad9467_delay_cal #(
        .DATA_WIDTH   (DW),
        .SETTLE_CYCLES(S),
        .CHECK_CYCLES (C),
        .MIN_WINDOW   (MW)
    ) dut (
        .up_clk          (clk),
        .up_rst          (up_rst),
        .cal_start       (cal_start),
        .cal_abort       (cal_abort),
        .up_status_pn_err(pn_err),
        .up_status_pn_oos(pn_oos),
        .up_drdata       (up_drdata),
        .up_dld          (up_dld),
        .up_dwdata       (up_dwdata),
        .cal_busy        (cal_busy),
        .cal_done        (cal_done),
        .cal_fail        (cal_fail),
        .cal_tap         (cal_tap),
        .cal_width       (cal_width)
    );

    initial begin
        for (int i = 0; i < DW; i++) drd[i] = 5'd0;
    end

    always_comb begin
        up_drdata = '0;
        for (int i = 0; i < DW; i++) begin
            up_drdata[5*i +: 5] = (stuck && i == 8) ? 5'd0 : drd[i];
        end
    end

    always @(negedge clk) begin
        logic [1:0] r;
        #1;
        if (up_dld != '0) begin
            dld_total++;
            cur_tap    = up_dwdata[4:0];
            since_load = 0;
            for (int i = 0; i < DW; i++) begin
                if (up_dld[i]) drd[i] = up_dwdata[5*i +: 5];
            end
        end else if (since_load < 1000) begin
            since_load++;
        end
        // Bad taps always report an error; good taps only glitch while settling
        if (!pass_mask[cur_tap]) begin
            r = 2'($urandom_range(1, 3));
        end else if (since_load >= 1 && since_load <= S) begin
            r = 2'($urandom_range(0, 3));
        end else begin
            r = 2'd0;
        end
        if (int'(cur_tap) == glitch_tap && since_load == S + C) r[1] = 1'b1;
        pn_err = r[0];
        pn_oos = r[1];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void best_window(input logic [31:0] m, output int bl, output int bs);
        int rl = 0;
        int rs = 0;
        bl = 0;
        bs = 0;
        for (int i = 0; i <= 32; i++) begin
            if (i < 32 && m[i]) begin
                if (rl == 0) rs = i;
                rl++;
            end else begin
                if (rl > bl) begin
                    bl = rl;
                    bs = rs;
                end
                rl = 0;
            end
        end
    endfunction

    task automatic run_cal(input string tag, input logic [31:0] mask, input int glitch,
                           input bit stuck_lane);
        int bl, bs, ctr, exp_cycles, d0, cycles;
        bit ok;
        logic [31:0] eff;
        pass_mask  = mask;
        glitch_tap = glitch;
        stuck      = stuck_lane;
        eff = mask;
        if (glitch >= 0) eff[glitch] = 1'b0;
        best_window(eff, bl, bs);
        ctr = bs + (bl - 1) / 2;
        ok  = (bl >= MW) && !(stuck_lane && ctr != 0);
        exp_cycles = 32 * (2 + S + C) + ((bl >= MW) ? (S + 3) : 1);

        d0 = dld_total;
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        cycles = 0;
        while (cal_busy === 1'b1 && cycles < 5000) begin
            cycles++;
            cal_start = (cycles == 100);
            @(negedge clk);
        end
        cal_start = 1'b0;
        check({tag, " finished"}, cycles < 5000, 1);
        check({tag, " busy cycles"}, cycles, exp_cycles);
        check({tag, " done"}, cal_done, ok);
        check({tag, " fail"}, cal_fail, !ok);
        check({tag, " tap"}, cal_tap, ok ? ctr : 0);
        check({tag, " width"}, cal_width, bl);
        check({tag, " load pulses"}, dld_total - d0, (bl >= MW) ? 33 : 32);
    endtask

    initial begin
        logic [31:0] m;
        int n;
        repeat (3) @(negedge clk);
        check("rst busy", cal_busy, 0);
        check("rst done", cal_done, 0);
        check("rst fail", cal_fail, 0);
        check("rst tap", cal_tap, 0);
        check("rst width", cal_width, 0);
        check("rst dld", up_dld, 0);
        check("rst dwdata", up_dwdata, 0);
        up_rst = 1'b0;
        repeat (2) @(negedge clk);

        run_cal("win10_17", 32'h0003_FC00, -1, 1'b0);
        run_cal("tie2_5_20_23", 32'h00F0_003C, -1, 1'b0);
        run_cal("all_pass", 32'hFFFF_FFFF, -1, 1'b0);
        run_cal("only30_31", 32'hC000_0000, -1, 1'b0);
        run_cal("oos_glitch12", 32'h001F_FF00, 12, 1'b0);
        run_cal("stuck_lane8", 32'h0003_FC00, -1, 1'b1);

        for (int k = 0; k < 6; k++) begin
            int ws, wl;
            m = $urandom() & $urandom();
            if (k % 2 == 0) begin
                ws = $urandom_range(0, 28);
                wl = $urandom_range(1, 12);
                for (int j = ws; j < ws + wl && j < 32; j++) m[j] = 1'b1;
            end
            run_cal($sformatf("rand%0d", k), m, (k == 4) ? int'($urandom_range(0, 31)) : -1,
                    k == 3);
        end

        // Abort while checking tap 5
        pass_mask = 32'hFFFF_FFFF;
        glitch_tap = -1;
        stuck = 1'b0;
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        n = 0;
        while (!(cur_tap == 5'd5 && since_load == S + 1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort reached tap5", n < 2000, 1);
        check("abort busy before", cal_busy, 1);
        cal_abort = 1'b1;
        @(negedge clk) cal_abort = 1'b0;
        check("abort busy", cal_busy, 0);
        check("abort fail", cal_fail, 1);
        check("abort done", cal_done, 0);
        check("abort dld", up_dld, 0);
        repeat (3) @(negedge clk);

        // Reset while settling after a successful run
        run_cal("pre_reset", 32'hFFFF_FFFF, -1, 1'b0);
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        n = 0;
        while (!(cur_tap == 5'd3 && since_load == 1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reset reached settle", n < 2000, 1);
        up_rst = 1'b1;
        n = dld_total;
        @(negedge clk) up_rst = 1'b0;
        check("mid rst busy", cal_busy, 0);
        check("mid rst done", cal_done, 0);
        check("mid rst fail", cal_fail, 0);
        check("mid rst tap", cal_tap, 0);
        check("mid rst width", cal_width, 0);
        check("mid rst dld", up_dld, 0);
        check("mid rst dwdata", up_dwdata, 0);
        repeat (4) @(negedge clk);
        check("no load after rst", dld_total - n, 0);

        run_cal("post_reset", 32'h0003_FC00, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
